switch_box_element_cfg: RTL

SWITCH_BOX_ELEMENT_CFG -- requirements
Module: switch_box_element_cfg

---
 rtl/switch_box_element_cfg.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/switch_box_element_cfg.sv
// ---------------------------------------------------------------------------
// switch_box_element_cfg
//
// A programmable routing switch box. It has WIDTH tracks on each of the four
// sides. Output track t on any side draws only from input track t on the
// other three sides, so tracks never mix. For each output there is a 2-bit
// select and a 1-bit register-mode flag. When the flag is set, the output
// comes from a flop with one cycle of latency instead of directly from the
// mux.
//
// The configuration is loaded serially into a shadow chain. It is then
// copied into the active configuration by a commit. The commit is accepted
// only when exactly CFG_BITS shift cycles have occurred since the previous
// commit attempt. Any other count is rejected and flagged on cfg_err.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   north_in    WIDTH routing inputs, north side (east/south/west likewise)
//   north_out   WIDTH routing outputs, north side (east/south/west likewise)
//   cfg_shift   shift cfg_in into the top of the shadow chain this cycle
//   cfg_in      serial configuration data
//   cfg_out     shadow chain tail (shadow[0]), for daisy-chaining
//   cfg_commit  request to copy shadow into the active configuration
//   cfg_valid   an active configuration has been committed since reset
//   cfg_err     sticky: the last commit attempt was rejected
//
// Per-track field, at bits [12t+11:12t]:
//   [1:0] north sel  [3:2] east sel  [5:4] south sel  [7:6] west sel
//   [8] north reg    [9] east reg    [10] south reg   [11] west reg
// ---------------------------------------------------------------------------
module switch_box_element_cfg #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CFG_BITS = 12 * WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] north_in,
  input  logic [WIDTH-1:0] east_in,
  input  logic [WIDTH-1:0] south_in,
  input  logic [WIDTH-1:0] west_in,
  output logic [WIDTH-1:0] north_out,
  output logic [WIDTH-1:0] east_out,
  output logic [WIDTH-1:0] south_out,
  output logic [WIDTH-1:0] west_out,
  input  logic             cfg_shift,
  input  logic             cfg_in,
  output logic             cfg_out,
  input  logic             cfg_commit,
  output logic             cfg_valid,
  output logic             cfg_err
);

  localparam int unsigned CNT_W = $clog2(CFG_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CFG_BITS + 1);

  // Reset value per track: every select is 3 (constant 0) and no register mode.
  localparam logic [CFG_BITS-1:0] ACTIVE_RST = {WIDTH{12'h0FF}};

  typedef enum logic [1:0] {
    IDLE,
    LOADING,
    OVERRUN
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [CFG_BITS-1:0] shadow;
  logic [CFG_BITS-1:0] active;

  logic [WIDTH-1:0] mux_n, mux_e, mux_s, mux_w;
  logic [WIDTH-1:0] flop_n, flop_e, flop_s, flop_w;

  assign cfg_out = shadow[0];

  // ---------------------------------------------------------------------
  // Configuration chain, shift counter and commit FSM.
  // The state always agrees with cnt:
  //   IDLE    when cnt == 0
  //   LOADING when 0 < cnt <= CFG_BITS
  //   OVERRUN when cnt == CFG_BITS+1 (cnt saturates there)
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      shadow    <= '0;
      active    <= ACTIVE_RST;
      cfg_valid <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      if (cfg_shift) begin
        shadow <= {cfg_in, shadow[CFG_BITS-1:1]};
      end

      if (cfg_commit) begin
        // A commit always restarts the count. If a shift happens in the same
        // cycle, it still moves the chain but is not counted, and it forces
        // the commit to be rejected.
        state <= IDLE;
        cnt   <= '0;
        if (!cfg_shift && state == LOADING && cnt == CNT_FULL) begin
          active    <= shadow;
          cfg_valid <= 1'b1;
          cfg_err   <= 1'b0;
        end else begin
          cfg_err   <= 1'b1;
        end
      end else if (cfg_shift) begin
        case (state)
          IDLE: begin
            state <= LOADING;
            cnt   <= CNT_W'(1);
          end
          LOADING: begin
            if (cnt == CNT_FULL) begin
              state <= OVERRUN;
              cnt   <= CNT_SAT;
            end else begin
              cnt   <= cnt + CNT_W'(1);
            end
          end
          default: begin
            state <= OVERRUN;
            cnt   <= CNT_SAT;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------
  // Per-track selection muxes (disjoint topology).
  // ---------------------------------------------------------------------
  always_comb begin
    mux_n = '0;
    mux_e = '0;
    mux_s = '0;
    mux_w = '0;
    for (int unsigned t = 0; t < WIDTH; t++) begin
      case (active[12*t +: 2])
        2'd0:    mux_n[t] = east_in[t];
        2'd1:    mux_n[t] = south_in[t];
        2'd2:    mux_n[t] = west_in[t];
        default: mux_n[t] = 1'b0;
      endcase
      case (active[12*t+2 +: 2])
        2'd0:    mux_e[t] = south_in[t];
        2'd1:    mux_e[t] = west_in[t];
        2'd2:    mux_e[t] = north_in[t];
        default: mux_e[t] = 1'b0;
      endcase
      case (active[12*t+4 +: 2])
        2'd0:    mux_s[t] = west_in[t];
        2'd1:    mux_s[t] = north_in[t];
        2'd2:    mux_s[t] = east_in[t];
        default: mux_s[t] = 1'b0;
      endcase
      case (active[12*t+6 +: 2])
        2'd0:    mux_w[t] = north_in[t];
        2'd1:    mux_w[t] = east_in[t];
        2'd2:    mux_w[t] = south_in[t];
        default: mux_w[t] = 1'b0;
      endcase
    end
  end

  // The output flops load every cycle, whether or not register mode is
  // selected. Turning register mode on therefore never shows data that is
  // more than one cycle old.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flop_n <= '0;
      flop_e <= '0;
      flop_s <= '0;
      flop_w <= '0;
    end else begin
      flop_n <= mux_n;
      flop_e <= mux_e;
      flop_s <= mux_s;
      flop_w <= mux_w;
    end
  end

  // Per-output choice between the combinational mux and the registered path.
  always_comb begin
    north_out = '0;
    east_out  = '0;
    south_out = '0;
    west_out  = '0;
    for (int unsigned t = 0; t < WIDTH; t++) begin
      north_out[t] = active[12*t+8]  ? flop_n[t] : mux_n[t];
      east_out[t]  = active[12*t+9]  ? flop_e[t] : mux_e[t];
      south_out[t] = active[12*t+10] ? flop_s[t] : mux_s[t];
      west_out[t]  = active[12*t+11] ? flop_w[t] : mux_w[t];
    end
  end

endmodule
